// File: rtl/d_mem_write_buffer_pkg.sv
// Shared encodings and default geometry for the D-memory posted-store write buffer.
package d_mem_write_buffer_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 12;
  localparam int WB_DW    = 32;
  localparam int WB_BEW   = WB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_WAIT = 2'd2
  } wb_state_e;

endpackage

// File: rtl/d_mem_write_buffer_if.sv
// Request/response bus from the D-cache plus the D-memory macro port; master = requester, slave = buffer, mem = macro.
interface d_mem_write_buffer_if
  import d_mem_write_buffer_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW
);
  localparam int BW = DW / 8;

  logic          req_csn;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_di;
  logic          rdy;
  logic          valid;
  logic [DW-1:0] req_dout;
  logic          d_mem_csn;
  logic          d_mem_wen;
  logic [AW-1:0] d_mem_addr;
  logic [BW-1:0] d_mem_be;
  logic [DW-1:0] d_mem_dout;
  logic [DW-1:0] d_mem_di;
  logic          wb_empty;
  logic          wb_full;

  modport master (
    output req_csn, req_wen, req_addr, req_be, req_di,
    input  rdy, valid, req_dout, wb_empty, wb_full
  );

  modport slave (
    input  req_csn, req_wen, req_addr, req_be, req_di, d_mem_di,
    output rdy, valid, req_dout, wb_empty, wb_full,
    output d_mem_csn, d_mem_wen, d_mem_addr, d_mem_be, d_mem_dout
  );

  modport mem (
    input  d_mem_csn, d_mem_wen, d_mem_addr, d_mem_be, d_mem_dout,
    output d_mem_di
  );

endinterface

// File: rtl/d_mem_write_buffer_wb_fifo.sv
// Circular store-entry storage: push at tail, pop at head, per-slot address match and youngest-entry byte merge.
module wb_fifo
  import d_mem_write_buffer_pkg::*;
#(
  parameter int  DEPTH = WB_DEPTH,
  parameter int  AW    = WB_AW,
  parameter int  DW    = WB_DW,
  localparam int BW    = DW / 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             merge_i,
  input  logic             pop_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [BW-1:0]    be_i,
  input  logic [DW-1:0]    data_i,
  output logic [DEPTH-1:0] match_o,
  output logic             young_match_o,
  output logic [AW-1:0]    head_addr_o,
  output logic [BW-1:0]    head_be_o,
  output logic [DW-1:0]    head_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [BW-1:0] be_q   [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, young;
  logic [CW-1:0] count_q;
  logic [PW-1:0] offs;

  assign young         = tail_q - PW'(1);
  assign young_match_o = (count_q != '0) && (addr_q[young] == addr_i);
  assign head_addr_o   = addr_q[head_q];
  assign head_be_o     = be_q[head_q];
  assign head_data_o   = data_q[head_q];
  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CW'(DEPTH));

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    match_o = '0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs       = PW'(i) - head_q;
      match_o[i] = (CW'(offs) < count_q) && (addr_q[i] == addr_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= addr_i;
      be_q[tail_q]   <= be_i;
      data_q[tail_q] <= data_i;
    end
    if (merge_i) begin
      be_q[young] <= be_q[young] | be_i;
      for (int b = 0; b < BW; b++) begin
        if (be_i[b]) data_q[young][8*b +: 8] <= data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/d_mem_write_buffer.sv
// Posted-store write buffer in front of D-memory; loads bypass unless they hit a queued word (then drain first).
// Load data VALID three cycles after accept; RDY holds the requester. WB_MERGE_EN enables youngest-entry store merging.
module d_mem_write_buffer
  import d_mem_write_buffer_pkg::*;
#(
  parameter int  DEPTH = WB_DEPTH,
  parameter int  AW    = WB_AW,
  parameter int  DW    = WB_DW,
  localparam int BW    = DW / 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input logic                  clk,
  input logic                  rst,
  d_mem_write_buffer_if.slave  bus
);

`ifdef WB_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  wb_state_e     state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] dout_q, dout_d;

  logic [DEPTH-1:0] match;
  logic             young_match, empty, full;
  logic [AW-1:0]    head_addr;
  logic [BW-1:0]    head_be;
  logic [DW-1:0]    head_data;
  logic [CW-1:0]    count;
  logic is_store, is_load, hit, load_acc, drain, merge, store_acc, push;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .merge_i      (merge),
    .pop_i        (drain),
    .addr_i       (bus.req_addr),
    .be_i         (bus.req_be),
    .data_i       (bus.req_di),
    .match_o      (match),
    .young_match_o(young_match),
    .head_addr_o  (head_addr),
    .head_be_o    (head_be),
    .head_data_o  (head_data),
    .count_o      (count),
    .empty_o      (empty),
    .full_o       (full)
  );

  // A non-hit load wins the memory port; a hitting load forces the drain that clears its hazard.
  always_comb begin
    is_store  = !bus.req_csn && !bus.req_wen;
    is_load   = !bus.req_csn && bus.req_wen;
    hit       = |match;
    load_acc  = is_load && !hit && (state_q == ST_IDLE);
    drain     = (state_q == ST_IDLE) && !empty && !load_acc &&
                (bus.req_csn || full || (is_load && hit));
    merge     = MERGE_EN && is_store && young_match && !(drain && count == CW'(1));
    store_acc = is_store && (!full || merge);
    push      = store_acc && !merge;
  end

  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    valid_d        = 1'b0;
    dout_d         = dout_q;
    bus.d_mem_csn  = 1'b1;
    bus.d_mem_wen  = 1'b1;
    bus.d_mem_addr = '0;
    bus.d_mem_be   = '0;
    bus.d_mem_dout = '0;
    case (state_q)
      ST_IDLE: begin
        if (load_acc) begin
          rd_addr_d = bus.req_addr;
          state_d   = ST_RD;
        end else if (drain) begin
          bus.d_mem_csn  = 1'b0;
          bus.d_mem_wen  = 1'b0;
          bus.d_mem_addr = head_addr;
          bus.d_mem_be   = head_be;
          bus.d_mem_dout = head_data;
        end
      end
      ST_RD: begin
        bus.d_mem_csn  = 1'b0;
        bus.d_mem_addr = rd_addr_q;
        bus.d_mem_be   = '1;
        state_d        = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        dout_d  = bus.d_mem_di;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.rdy      = store_acc || load_acc;
  assign bus.valid    = valid_q;
  assign bus.req_dout = dout_q;
  assign bus.wb_empty = empty;
  assign bus.wb_full  = full;

endmodule
